// File: rtl/hpdcache_mem_read_responder.sv
// hpdcache_mem_read_responder: burst read responder backed by a 1-cycle-latency beat RAM
module hpdcache_mem_read_responder #(
  parameter int PA_WIDTH       = 49,
  parameter int MEM_DATA_WIDTH = 128,
  parameter int MEM_ID_WIDTH   = 4,
  parameter int RAM_ADDR_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mem_req_valid_i,
  output logic                      mem_req_ready_o,
  input  logic [PA_WIDTH-1:0]       mem_req_addr_i,
  input  logic [7:0]                mem_req_len_i,
  input  logic [MEM_ID_WIDTH-1:0]   mem_req_id_i,
  output logic                      mem_resp_valid_o,
  input  logic                      mem_resp_ready_i,
  output logic [MEM_DATA_WIDTH-1:0] mem_resp_data_o,
  output logic [MEM_ID_WIDTH-1:0]   mem_resp_id_o,
  output logic                      mem_resp_last_o,
  output logic                      mem_resp_error_o,
  output logic                      ram_req_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] ram_rdata_i
);
  localparam int OFF = $clog2(MEM_DATA_WIDTH / 8);
  localparam int BW  = PA_WIDTH - OFF;
  localparam int EW  = MEM_DATA_WIDTH + MEM_ID_WIDTH + 2;
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [BW-1:0] beat_addr;
  logic [7:0] remaining;
  logic [MEM_ID_WIDTH-1:0] id_q, fl_id;
  logic fl_valid, fl_ram, fl_last;
  logic [EW-1:0] fifo [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count, occ;
  logic accept, issue, done, in_range, pop;
  logic [MEM_DATA_WIDTH-1:0] push_data;
  logic unused_lo;
  assign unused_lo = ^mem_req_addr_i[OFF-1:0];
  assign accept = mem_req_valid_i & mem_req_ready_o;
  assign mem_resp_valid_o = count != 2'd0;
  assign pop = mem_resp_valid_o & mem_resp_ready_i;
  // a beat popping this cycle frees its slot, which keeps 1 beat/cycle streaming
  assign occ = count + {1'b0, fl_valid};
  assign issue = (state == BURST) && (occ < 2'd2 || (pop && occ == 2'd2));
  assign done = issue && remaining == 8'd0;
  assign in_range = (beat_addr >> RAM_ADDR_WIDTH) == '0;
  assign push_data = fl_ram ? ram_rdata_i : {MEM_DATA_WIDTH{1'b0}};
  assign {mem_resp_data_o, mem_resp_id_o, mem_resp_last_o, mem_resp_error_o} = fifo[rd_ptr];

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  end

  // next state: one request in service; leave BURST right after issuing its last beat
  always_comb begin
    state_n = state == IDLE ? (accept ? BURST : IDLE) : (done ? IDLE : BURST);
  end

  // FSM outputs: request handshake and RAM strobe (out-of-range beats skip the RAM)
  always_comb begin
    mem_req_ready_o = state == IDLE;
    ram_req_o = issue && in_range;
    ram_addr_o = beat_addr[RAM_ADDR_WIDTH-1:0];
  end

  // burst context and the single-beat RAM flight stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_addr <= '0;
      remaining <= '0;
      id_q <= '0;
      fl_valid <= 1'b0;
      fl_ram <= 1'b0;
      fl_last <= 1'b0;
      fl_id <= '0;
    end else begin
      if (accept) begin
        beat_addr <= mem_req_addr_i[PA_WIDTH-1:OFF];
        remaining <= mem_req_len_i;
        id_q <= mem_req_id_i;
      end else if (issue) begin
        beat_addr <= beat_addr + BW'(1);
        remaining <= remaining - 8'd1;
      end
      fl_valid <= issue;
      fl_ram <= issue && in_range;
      fl_last <= done;
      fl_id <= id_q;
    end
  end

  // two-entry response FIFO filled from the flight stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (fl_valid) fifo[wr_ptr] <= {push_data, fl_id, fl_last, ~fl_ram};
      wr_ptr <= wr_ptr ^ fl_valid;
      rd_ptr <= rd_ptr ^ pop;
      count <= count + {1'b0, fl_valid} - {1'b0, pop};
    end
  end
endmodule
